riscv_pipe_ctrl: RTL
====================

// Module: riscv_pipe_ctrl
// PURPOSE
//  Parametrised hazard/stall/flush controller for the RISC-V pipeline; fills the stall-control slot in the core top.
//  Keeps a STAGES-deep shift scoreboard of in-flight writers (EX..WB), detects RAW and load-use hazards for the ID instruction,
//  drives stall/bubble/flush, produces registered EX forwarding selects and saturating stall/flush performance counters.
// PARAMETERS
//  STAGES  3   tracked stages after ID: index 0=EX, 1=MEM, ..., STAGES-1=WB; legal range >=2
//  REG_AW  5   register index width
//  CNT_W   16  width of the performance counters
//  FSEL_W  localparam = max(1,$clog2(STAGES)); width of the forwarding selects
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous reset, active low
//  id_valid_i    in   1       ID holds a real instruction
//  id_rs1_i      in   REG_AW  ID source register 1 index
//  id_rs2_i      in   REG_AW  ID source register 2 index
//  id_rs1_use_i  in   1       ID instruction reads rs1
//  id_rs2_use_i  in   1       ID instruction reads rs2
//  id_rd_i       in   REG_AW  ID destination index
//  id_rd_we_i    in   1       ID instruction writes rd
//  id_load_i     in   1       ID instruction is a load
//  br_taken_i    in   1       branch/jump resolved taken in EX this cycle
//  stall_o       out  1       hold PC and IF/ID register
//  bubble_o      out  1       load NOP into ID/EX register
//  flush_o       out  1       load NOP into IF/ID register
//  fwd_a_sel_o   out  FSEL_W  EX operand A source: 0=ID/EX value, k=result of stage k (1..STAGES-1)
//  fwd_b_sel_o   out  FSEL_W  EX operand B source, same encoding
//  stall_cnt_o   out  CNT_W   cycles with stall_o=1, saturating
//  flush_cnt_o   out  CNT_W   cycles with flush_o=1, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): all scoreboard entries invalid, fwd selects 0, counters 0; so stall_o=bubble_o=0.
//  - Scoreboard entry = {valid, rd, we, load}. Shifts every cycle (back end never stalls): e[k]<=e[k-1];
//    e[0]<=ID fields if id_valid_i & !stall_o & !br_taken_i, else invalid. Entry at STAGES-1 drops out next cycle.
//  - Match(src, k): src_use & src!=0 & e[k].valid & e[k].we & e[k].rd==src. x0 never hazards.
//  - Hazard (FORWARD_EN set): load-use only: Match(any src, 0) with e[0].load. One stall cycle per load-use.
//  - stall_o = id_valid_i & hazard & !br_taken_i (combinational). bubble_o = stall_o | br_taken_i. flush_o = br_taken_i.
//  - Branch taken with hazard in same cycle: flush wins; stall_o=0, bubble_o=1, flush_o=1; ID instruction killed.
//  - Forward select (registered, valid while consumer in EX): on the edge ID enters EX, per source take the
//    youngest (lowest k) matching entry j; sel<=j+1 if j+1<=STAGES-1, else 0; no match ->0. When ID does not
//    enter EX (stall/flush/invalid) sel<=0. Youngest-wins guarantees correct value on repeated rd writes.
//  - WB-stage writer (k=STAGES-1) is never a hazard: register file is write-through in the same cycle.
//  - Counters +1 per cycle of stall_o / flush_o; hold at all-ones (no wrap).
//  - Reset mid-stall: scoreboard cleared immediately, stall_o drops in the same cycle rst_n falls.
// CONFIGURATION
//  RISCV_PIPE_FWD_EN defined: forwarding as above; only load-use stalls.
//  RISCV_PIPE_FWD_EN undefined: fwd_*_sel_o tied 0; hazard = Match(any src, k) for any k in 0..STAGES-2
//    (any in-flight writer before WB); ID stalls until the producer reaches WB.
// TESTING
//  1 FWD_EN: addi x5 then add x6,x5,x5 back-to-back -> no stall; next cycle fwd_a_sel_o=fwd_b_sel_o=1.
//  2 FWD_EN: lw x7 then add x8,x7,x0 -> stall_o=bubble_o=1 exactly 1 cycle; then fwd_a_sel_o=2, fwd_b_sel_o=0.
//  3 no FWD_EN, STAGES=3: addi x5 then use x5 -> stall_o=1 for 2 cycles, fwd selects remain 0, stall_cnt_o=2.
//  4 br_taken_i=1 with load-use hazard pending -> stall_o=0, bubble_o=1, flush_o=1, flush_cnt_o +1, no entry for ID.
//  5 writes to x0 then reads of x0 -> never stall, sels 0; two writers to x9 in EX,MEM -> sel picks 1 (youngest).
//  6 CNT_W=2, stall 5 cycles -> stall_cnt_o=3 held; rst_n low mid-stall -> stall_o=0 immediately, counters 0.

Source files
------------

// File: rtl/riscv_pipe_ctrl.sv
// riscv_pipe_ctrl: hazard, stall and flush controller for the in-order RISC-V pipeline.
// Tracks the writers in flight after ID (EX..WB) in a shift scoreboard, detects RAW and
// load-use hazards for the ID instruction, drives stall/bubble/flush, registers the EX
// forwarding selects and keeps saturating stall/flush cycle counters.
// Build option: define RISCV_PIPE_FWD_EN to enable forwarding; then only load-use
// hazards stall. Without it the forwarding selects are tied to 0 and ID waits until
// every matching producer has reached WB.
module riscv_pipe_ctrl #(
  parameter int unsigned  STAGES = 3,
  parameter int unsigned  REG_AW = 5,
  parameter int unsigned  CNT_W  = 16,
  localparam int unsigned FSEL_W = ($clog2(STAGES) > 1) ? $clog2(STAGES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_use_i,
  input  logic              id_rs2_use_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_rd_we_i,
  input  logic              id_load_i,
  input  logic              br_taken_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic [FSEL_W-1:0] fwd_a_sel_o,
  output logic [FSEL_W-1:0] fwd_b_sel_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // Scoreboard, index 0 = EX, STAGES-1 = WB
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_we;
  logic [STAGES-1:0] r_ld;
  logic [REG_AW-1:0] r_rd [STAGES];

  logic [STAGES-1:0] w_m1;
  logic [STAGES-1:0] w_m2;
  logic              w_hazard;
  logic              w_stall;
  logic              w_enter;
  logic              w_unused;

  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  // Per-stage source match; x0 and unused sources never match
  always_comb begin
    w_m1 = '0;
    w_m2 = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      w_m1[k] = id_rs1_use_i && (id_rs1_i != '0) && r_vld[k] && r_we[k] &&
                (r_rd[k] == id_rs1_i);
      w_m2[k] = id_rs2_use_i && (id_rs2_i != '0) && r_vld[k] && r_we[k] &&
                (r_rd[k] == id_rs2_i);
    end
  end

`ifdef RISCV_PIPE_FWD_EN
  // Only a load sitting in EX cannot be forwarded in time
  assign w_hazard = (w_m1[0] | w_m2[0]) & r_ld[0];
  // Load flag past EX and the WB-stage match bits carry no decision in this mode
  assign w_unused = r_ld[STAGES-1];
`else
  // Any writer not yet in WB blocks the reader; WB writes through the register file
  assign w_hazard = |(w_m1[STAGES-2:0] | w_m2[STAGES-2:0]);
  assign w_unused = ^{r_ld[STAGES-1], w_m1[STAGES-1], w_m2[STAGES-1]};
`endif

  // A taken branch kills the ID instruction, so it overrides the stall
  assign w_stall  = id_valid_i & w_hazard & ~br_taken_i;
  assign w_enter  = id_valid_i & ~w_stall & ~br_taken_i;

  assign stall_o  = w_stall;
  assign bubble_o = w_stall | br_taken_i;
  assign flush_o  = br_taken_i;

  // Scoreboard shifts every cycle; the back end never stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_we  <= '0;
      r_ld  <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        r_rd[k] <= '0;
      end
    end else begin
      r_vld    <= {r_vld[STAGES-2:0], w_enter};
      r_we     <= {r_we[STAGES-2:0], w_enter & id_rd_we_i};
      r_ld     <= {r_ld[STAGES-2:0], w_enter & id_load_i};
      r_rd[0]  <= id_rd_i;
      for (int k = 1; k < int'(STAGES); k++) begin
        r_rd[k] <= r_rd[k-1];
      end
    end
  end

`ifdef RISCV_PIPE_FWD_EN
  logic [FSEL_W-1:0] w_sel_a;
  logic [FSEL_W-1:0] w_sel_b;
  logic [FSEL_W-1:0] r_fwd_a;
  logic [FSEL_W-1:0] r_fwd_b;

  // Youngest match wins: scan oldest to youngest so the lowest index is written last
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      if (w_m1[k]) w_sel_a = (k < int'(STAGES) - 1) ? FSEL_W'(k + 1) : '0;
      if (w_m2[k]) w_sel_b = (k < int'(STAGES) - 1) ? FSEL_W'(k + 1) : '0;
    end
  end

  // Selects are captured as the consumer moves into EX, cleared otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end else begin
      r_fwd_a <= w_enter ? w_sel_a : '0;
      r_fwd_b <= w_enter ? w_sel_b : '0;
    end
  end

  assign fwd_a_sel_o = r_fwd_a;
  assign fwd_b_sel_o = r_fwd_b;
`else
  assign fwd_a_sel_o = '0;
  assign fwd_b_sel_o = '0;
`endif

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (br_taken_i && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule
